move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Upstream feeder for the six per-face stepper drivers of the cube robot.
- Buffers a queued solve sequence of face moves in a FIFO.
- On `go`, issues each move in order: a one-cycle start pulse, a step count and a direction to the selected face's driver. It then waits for that driver's done handshake, inserts a settle gap, and proceeds to the next move.
- Exactly one motor moves at a time.

Parameters:
- DEPTH, 32, FIFO entries; power of 2, at least 2.
- STEPS_PER_QUARTER, 50, driver steps for a 90° turn. Must satisfy 2*STEPS_PER_QUARTER+51 ≤ 255, because the driver adds 51 internally to an 8-bit counter.
- NUM_MOTORS, 6, number of face drivers; one-hot outputs are this wide.
- SETTLE_CYCLES, 1000, idle clock cycles between a driver's done and the next start; must be at least 1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears FIFO, FSM and all outputs.
- move_valid  in  1  a move is presented on move_data.
- move_data  in  5  {face[2:0], ccw, half}. face is 0..5; ccw=1 selects counter-clockwise; half=1 selects a 180° turn.
- move_ready  out  1  equals !full. A write occurs on move_valid & move_ready.
- go  in  1  start executing the queue; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- motor_start  out  NUM_MOTORS  one-hot start pulse, exactly one cycle wide.
- motor_steps  out  8  step count, shared by all drivers.
- motor_dir  out  NUM_MOTORS  per-motor direction, 1 = ccw.
- motor_done  in  NUM_MOTORS  per-driver done, level signal.
- seq_done  out  1  one-cycle pulse when the queue drains.
- error  out  1  sticky: a move with face ≥ NUM_MOTORS was presented.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - motor_start = 0, motor_steps = 0, motor_dir = 0.
  - busy = 0, seq_done = 0, error = 0, count = 0.
  - move_ready = 1, FSM = IDLE.
- Reset asserted mid-move:
  - Queue is flushed and motor_start drops immediately.
  - The in-flight driver is not aborted; its own state is outside this block.
- FIFO input:
  - Write pointer and read pointer wrap modulo DEPTH.
  - When full, move_ready = 0 and move_valid is ignored; there is no bypass.
  - A move with face ≥ NUM_MOTORS is consumed (handshake completes) but not stored, and error is set. error clears only on reset.
  - Writes are allowed in every state, including while executing. A write and a pop in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, SETTLE.
- IDLE:
  - If go is high and count > 0, go to ISSUE next cycle.
  - If go is high and the FIFO is empty, go is ignored and there is no seq_done.
- ISSUE (exactly 1 cycle):
  - Pop the head entry.
  - motor_start[face] = 1 for this single cycle.
  - motor_steps = half ? 2*STEPS_PER_QUARTER : STEPS_PER_QUARTER.
  - motor_dir[face] = ccw. Other motor_dir bits hold their previous values.
  - Latch face into cur_face. Next state: WAIT_ACK.
- Output timing: motor_steps and motor_dir are registered and valid in the ISSUE cycle. They are held until the next ISSUE, so they stay stable throughout the move.
- Latency: go is sampled high in IDLE at cycle N; motor_start is high at cycle N+1.
- WAIT_ACK:
  - Wait until motor_done[cur_face] = 0. The driver drops done one cycle after start, so a stale done from a previous move must not be taken as completion.
  - Then go to WAIT_DONE.
- WAIT_DONE:
  - Wait until motor_done[cur_face] = 1.
  - Then load the settle counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When it reaches 0: if count > 0, go to ISSUE; otherwise go to IDLE and pulse seq_done for 1 cycle in the same cycle busy falls.
- Sampling rules:
  - motor_done bits other than cur_face are ignored.
  - go is ignored while busy.
- No timeout: a driver that never completes holds the FSM in WAIT_ACK or WAIT_DONE until reset.

Test Plan:
1. Reset, then write {face=2, ccw=0, half=0}, then pulse go. Expect:
   - motor_start = 6'b000100 for exactly 1 cycle, one cycle after go.
   - motor_steps = 50, motor_dir[2] = 0.
   - busy stays high until done rises, plus 1000 cycles; then seq_done pulses once.
2. Queue three moves: f0 half cw, f5 quarter ccw, f3 quarter cw. Model drivers with done dropping 1 cycle after start and rising after steps+51 step ticks. Expect:
   - starts on bits 0, 5, 3 in order, with steps 100, 50, 50 and dir[5] = 1.
   - no overlapping starts.
   - SETTLE_CYCLES gap from each done to the next start.
3. Hold motor_done[cur_face] = 1 for 3 cycles after start (slow ack). Expect the FSM to stay in WAIT_ACK and not advance until done has gone low and then high again.
4. Fill the FIFO with 32 writes. Expect move_ready = 0 and count = 32; a 33rd write is dropped. Pop one via go; expect move_ready = 1 the next cycle.
5. Write face = 6. Expect error = 1 (sticky), count unchanged, and no motor_start after go on an otherwise empty queue.
6. Assert reset during WAIT_DONE with 4 moves queued. Expect count = 0, busy = 0 and motor_start = 0 immediately. A subsequent go issues nothing.

Source files
------------

// File: rtl/move_sequencer.sv
// Queues cube face moves and issues them one at a time to the per-face stepper
// drivers: start pulse, wait for the driver's done handshake, settle, repeat.
//
// state     | meaning
// IDLE      | waiting for go with a non-empty queue
// ISSUE     | start pulse out, head entry popped
// WAIT_ACK  | waiting for the selected driver to drop done
// WAIT_DONE | waiting for the selected driver to raise done
// SETTLE    | counting down the gap before the next move

module move_sequencer #(
   parameter int DEPTH             = 32,
   parameter int STEPS_PER_QUARTER = 50,
   parameter int NUM_MOTORS        = 6,
   parameter int SETTLE_CYCLES     = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    move_valid,
   input  logic [4:0]              move_data,
   output logic                    move_ready,
   input  logic                    go,
   output logic                    busy,
   output logic [NUM_MOTORS-1:0]   motor_start,
   output logic [7:0]              motor_steps,
   output logic [NUM_MOTORS-1:0]   motor_dir,
   input  logic [NUM_MOTORS-1:0]   motor_done,
   output logic                    seq_done,
   output logic                    error,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] FULL_COUNT    = CW'(DEPTH);
   localparam logic [SW-1:0] SETTLE_LOAD   = SW'(SETTLE_CYCLES);
   localparam logic [7:0]    STEPS_QUARTER = 8'(STEPS_PER_QUARTER);
   localparam logic [7:0]    STEPS_HALF    = 8'(2 * STEPS_PER_QUARTER);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      SETTLE
   } state_t;

   state_t                state_q, state_d;
   logic [4:0]            mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic [2:0]            cur_face_q, cur_face_d;
   logic [NUM_MOTORS-1:0] start_q, start_d;
   logic [NUM_MOTORS-1:0] dir_q, dir_d;
   logic [7:0]            steps_q, steps_d;
   logic                  busy_q, busy_d;
   logic                  seq_done_q, seq_done_d;
   logic                  error_q, error_d;
   logic                  push, bad_face, wr_en, pop, issue;
   logic [4:0]            head;

   assign head       = mem_q[rd_ptr_q];
   assign move_ready = (count_q != FULL_COUNT);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      settle_d   = settle_q;
      cur_face_d = cur_face_q;
      start_d    = '0;
      dir_d      = dir_q;
      steps_d    = steps_q;
      seq_done_d = 1'b0;
      error_d    = error_q;
      issue      = 1'b0;

      // Out-of-range faces complete the handshake but never reach the queue.
      push     = move_valid && move_ready;
      bad_face = (32'(move_data[4:2]) >= NUM_MOTORS);
      wr_en    = push && !bad_face;
      pop      = (state_q == ISSUE);

      if (push && bad_face) error_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (go && count_q != '0) issue = 1'b1;
         end
         ISSUE: state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (!motor_done[cur_face_q]) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (motor_done[cur_face_q]) begin
               settle_d = SETTLE_LOAD;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            settle_d = settle_q - SW'(1);
            if (settle_q == SW'(1)) begin
               if (count_q != '0) begin
                  issue = 1'b1;
               end else begin
                  state_d    = IDLE;
                  seq_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are loaded on the way into ISSUE so they are valid during it.
      if (issue) begin
         state_d             = ISSUE;
         cur_face_d          = head[4:2];
         start_d             = NUM_MOTORS'(1) << head[4:2];
         dir_d[head[4:2]]    = head[1];
         steps_d             = head[0] ? STEPS_HALF : STEPS_QUARTER;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         settle_q   <= '0;
         cur_face_q <= '0;
         start_q    <= '0;
         dir_q      <= '0;
         steps_q    <= '0;
         busy_q     <= 1'b0;
         seq_done_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         settle_q   <= settle_d;
         cur_face_q <= cur_face_d;
         start_q    <= start_d;
         dir_q      <= dir_d;
         steps_q    <= steps_d;
         busy_q     <= busy_d;
         seq_done_q <= seq_done_d;
         error_q    <= error_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= move_data;
   end

   assign motor_start = start_q;
   assign motor_steps = steps_q;
   assign motor_dir   = dir_q;
   assign busy        = busy_q;
   assign seq_done    = seq_done_q;
   assign error       = error_q;
   assign count       = count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: behavioural stepper-driver models, a move queue
// reference model and per-scenario timing/ordering checks.

module tb_move_sequencer;

   localparam int DEPTH  = 32;
   localparam int SPQ    = 50;
   localparam int NM     = 6;
   localparam int SETTLE = 1000;

   logic                    clock = 1'b0;
   logic                    reset = 1'b0;
   logic                    move_valid = 1'b0;
   logic [4:0]              move_data = '0;
   logic                    move_ready;
   logic                    go = 1'b0;
   logic                    busy;
   logic [NM-1:0]           motor_start;
   logic [7:0]              motor_steps;
   logic [NM-1:0]           motor_dir;
   logic [NM-1:0]           motor_done;
   logic                    seq_done;
   logic                    error;
   logic [$clog2(DEPTH):0]  count;

   move_sequencer #(
      .DEPTH(DEPTH), .STEPS_PER_QUARTER(SPQ), .NUM_MOTORS(NM), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clock(clock), .reset(reset), .move_valid(move_valid), .move_data(move_data),
      .move_ready(move_ready), .go(go), .busy(busy), .motor_start(motor_start),
      .motor_steps(motor_steps), .motor_dir(motor_dir), .motor_done(motor_done),
      .seq_done(seq_done), .error(error), .count(count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         c;
      logic [5:0] start;
      logic [7:0] steps;
      logic [5:0] dir;
   } start_ev_t;

   typedef struct {
      logic [2:0] face;
      logic       ccw;
      logic       half;
   } move_t;

   int          cyc = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   start_ev_t   starts[$];
   int          done_rise[$];
   int          sdone[$];
   int          busy_cycles = 0;
   int          ack_delay = 1;
   int          phase [NM];
   int          tmr [NM];
   int          run_len [NM];
   move_t       exp_q[$];
   int          mdl_cnt = 0;
   logic [5:0]  mdl_dir = '0;

   initial forever @(posedge clock) cyc++;

   // Drivers drop done ack_delay cycles after start, raise it steps+51 later.
   initial begin : drivers_and_monitor
      start_ev_t ev;
      motor_done = '1;
      for (int i = 0; i < NM; i++) begin
         phase[i] = 0; tmr[i] = 0; run_len[i] = 0;
      end
      forever begin
         @(negedge clock);
         if (motor_start != '0) begin
            ev.c = cyc; ev.start = motor_start; ev.steps = motor_steps; ev.dir = motor_dir;
            starts.push_back(ev);
            mdl_cnt--;
         end
         if (seq_done) sdone.push_back(cyc);
         if (busy) busy_cycles++;
         for (int i = 0; i < NM; i++) begin
            if (motor_start[i]) begin
               phase[i] = 1; tmr[i] = ack_delay; run_len[i] = int'(motor_steps) + 51;
            end else if (phase[i] == 1) begin
               tmr[i]--;
               if (tmr[i] == 0) begin motor_done[i] = 1'b0; phase[i] = 2; tmr[i] = run_len[i]; end
            end else if (phase[i] == 2) begin
               tmr[i]--;
               if (tmr[i] == 0) begin motor_done[i] = 1'b1; phase[i] = 0; done_rise.push_back(cyc); end
            end
         end
      end
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      starts.delete(); done_rise.delete(); sdone.delete(); busy_cycles = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; move_valid = 1'b0; go = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_q.delete(); mdl_cnt = 0; mdl_dir = '0;
   endtask

   task automatic write_move(input logic [2:0] f, input logic ccw, input logic half, input bit now);
      move_t mv;
      if (!now) @(negedge clock);
      move_valid = 1'b1;
      move_data  = {f, ccw, half};
      if (mdl_cnt < DEPTH && int'(f) < NM) begin
         mv.face = f; mv.ccw = ccw; mv.half = half;
         exp_q.push_back(mv);
         mdl_cnt++;
      end
      @(posedge clock);
      #1 move_valid = 1'b0;
   endtask

   task automatic pulse_go(output int gc);
      @(negedge clock);
      go = 1'b1; gc = cyc;
      @(negedge clock);
      go = 1'b0;
   endtask

   task automatic wait_seq(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(negedge clock);
         if (sdone.size() > 0) ok = 1'b1;
      end
      @(negedge clock);
   endtask

   function automatic move_t plan_move(input int i);
      move_t mv;
      case (i)
         0:       begin mv.face = 3'd0; mv.ccw = 1'b0; mv.half = 1'b1; end
         1:       begin mv.face = 3'd5; mv.ccw = 1'b1; mv.half = 1'b0; end
         default: begin mv.face = 3'd3; mv.ccw = 1'b0; mv.half = 1'b0; end
      endcase
      return mv;
   endfunction

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      #1;
      total_cnt++; if (motor_start !== '0) $display("FAIL reset_start: got %b want 0", motor_start); else pass_cnt++;
      total_cnt++; if (motor_steps !== '0) $display("FAIL reset_steps: got %0d want 0", motor_steps); else pass_cnt++;
      total_cnt++; if (motor_dir !== '0) $display("FAIL reset_dir: got %b want 0", motor_dir); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (seq_done !== 1'b0) $display("FAIL reset_seq_done: got %b want 0", seq_done); else pass_cnt++;
      total_cnt++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else pass_cnt++;
      total_cnt++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", move_ready); else pass_cnt++;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_q.delete(); mdl_cnt = 0; mdl_dir = '0;
   endtask

   task automatic test_single();
      int gc; bit ok;
      clear_logs();
      write_move(3'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      total_cnt++; if (count !== 6'(mdl_cnt)) $display("FAIL single_count: got %0d want %0d", count, mdl_cnt); else pass_cnt++;
      pulse_go(gc);
      wait_seq(3000, ok);
      total_cnt++; if (!ok) $display("FAIL single_timeout: got no seq_done want seq_done"); else pass_cnt++;
      total_cnt++; if (starts.size() != 1) $display("FAIL single_nstarts: got %0d want 1", starts.size()); else pass_cnt++;
      if (starts.size() >= 1) begin
         mdl_dir[2] = 1'b0;
         total_cnt++; if (starts[0].start !== 6'b000100) $display("FAIL single_start: got %b want 000100", starts[0].start); else pass_cnt++;
         total_cnt++; if (starts[0].c != gc + 1) $display("FAIL single_latency: got cycle %0d want %0d", starts[0].c, gc + 1); else pass_cnt++;
         total_cnt++; if (starts[0].steps !== 8'(SPQ)) $display("FAIL single_steps: got %0d want %0d", starts[0].steps, SPQ); else pass_cnt++;
         total_cnt++; if (starts[0].dir !== mdl_dir) $display("FAIL single_dir: got %b want %b", starts[0].dir, mdl_dir); else pass_cnt++;
      end
      total_cnt++; if (sdone.size() != 1) $display("FAIL single_nseqdone: got %0d want 1", sdone.size()); else pass_cnt++;
      if (sdone.size() >= 1 && done_rise.size() >= 1) begin
         total_cnt++; if (sdone[0] != done_rise[0] + SETTLE + 1) $display("FAIL single_settle: got seq_done cycle %0d want %0d", sdone[0], done_rise[0] + SETTLE + 1); else pass_cnt++;
         total_cnt++; if (busy_cycles != sdone[0] - gc - 1) $display("FAIL single_busy_len: got %0d want %0d", busy_cycles, sdone[0] - gc - 1); else pass_cnt++;
      end
      total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else pass_cnt++;
      exp_q.delete();
   endtask

   task automatic test_sequence(input bit rnd, input int n);
      int gc, m; bit ok; move_t mv; logic [5:0] es; logic [7:0] est;
      clear_logs();
      for (int i = 0; i < n; i++) begin
         if (rnd) begin
            mv.face = 3'($urandom_range(0, NM - 1));
            mv.ccw  = 1'($urandom_range(0, 1));
            mv.half = 1'($urandom_range(0, 1));
         end else begin
            mv = plan_move(i);
         end
         write_move(mv.face, mv.ccw, mv.half, 1'b0);
      end
      pulse_go(gc);
      if (rnd) begin
         // write lands in the same cycle as the first pop
         mv.face = 3'($urandom_range(0, NM - 1));
         mv.ccw  = 1'($urandom_range(0, 1));
         mv.half = 1'($urandom_range(0, 1));
         write_move(mv.face, mv.ccw, mv.half, 1'b1);
         @(negedge clock);
         total_cnt++; if (count !== 6'(mdl_cnt)) $display("FAIL seq_count_push_pop: got %0d want %0d", count, mdl_cnt); else pass_cnt++;
      end
      m = exp_q.size();
      wait_seq(m * 1400 + 500, ok);
      total_cnt++; if (!ok) $display("FAIL seq_timeout: got no seq_done want seq_done"); else pass_cnt++;
      total_cnt++; if (starts.size() != m) $display("FAIL seq_nstarts: got %0d want %0d", starts.size(), m); else pass_cnt++;
      for (int i = 0; i < m && i < starts.size(); i++) begin
         mv  = exp_q[i];
         es  = 6'b1 << mv.face;
         est = mv.half ? 8'(2 * SPQ) : 8'(SPQ);
         mdl_dir[mv.face] = mv.ccw;
         total_cnt++; if (starts[i].start !== es) $display("FAIL seq_start[%0d]: got %b want %b", i, starts[i].start, es); else pass_cnt++;
         total_cnt++; if (starts[i].steps !== est) $display("FAIL seq_steps[%0d]: got %0d want %0d", i, starts[i].steps, est); else pass_cnt++;
         total_cnt++; if (starts[i].dir !== mdl_dir) $display("FAIL seq_dir[%0d]: got %b want %b", i, starts[i].dir, mdl_dir); else pass_cnt++;
         if (i == 0) begin
            total_cnt++; if (starts[0].c != gc + 1) $display("FAIL seq_latency: got cycle %0d want %0d", starts[0].c, gc + 1); else pass_cnt++;
         end else if (i - 1 < done_rise.size()) begin
            total_cnt++; if (starts[i].c - done_rise[i-1] != SETTLE + 1) $display("FAIL seq_gap[%0d]: got %0d want %0d", i, starts[i].c - done_rise[i-1], SETTLE + 1); else pass_cnt++;
         end
      end
      total_cnt++; if (sdone.size() != 1) $display("FAIL seq_nseqdone: got %0d want 1", sdone.size()); else pass_cnt++;
      if (sdone.size() >= 1 && done_rise.size() >= 1) begin
         total_cnt++; if (sdone[0] != done_rise[done_rise.size()-1] + SETTLE + 1) $display("FAIL seq_done_time: got %0d want %0d", sdone[0], done_rise[done_rise.size()-1] + SETTLE + 1); else pass_cnt++;
      end
      exp_q.delete();
   endtask

   task automatic test_slow_ack();
      int gc; bit ok;
      clear_logs();
      ack_delay = 4;
      write_move(3'd1, 1'b1, 1'b0, 1'b0);
      pulse_go(gc);
      wait_seq(3000, ok);
      ack_delay = 1;
      mdl_dir[1] = 1'b1;
      total_cnt++; if (!ok) $display("FAIL slow_timeout: got no seq_done want seq_done"); else pass_cnt++;
      total_cnt++; if (starts.size() != 1) $display("FAIL slow_nstarts: got %0d want 1", starts.size()); else pass_cnt++;
      total_cnt++; if (motor_dir !== mdl_dir) $display("FAIL slow_dir: got %b want %b", motor_dir, mdl_dir); else pass_cnt++;
      if (sdone.size() >= 1 && done_rise.size() >= 1) begin
         total_cnt++; if (sdone[0] != done_rise[0] + SETTLE + 1) $display("FAIL slow_seq_done: got %0d want %0d", sdone[0], done_rise[0] + SETTLE + 1); else pass_cnt++;
         total_cnt++; if (busy_cycles != sdone[0] - gc - 1) $display("FAIL slow_busy_len: got %0d want %0d", busy_cycles, sdone[0] - gc - 1); else pass_cnt++;
      end
      exp_q.delete();
   endtask

   task automatic test_bad_face();
      do_reset();
      clear_logs();
      write_move(3'd6, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      total_cnt++; if (error !== 1'b1) $display("FAIL bad_error: got %b want 1", error); else pass_cnt++;
      total_cnt++; if (count !== 6'(mdl_cnt)) $display("FAIL bad_count: got %0d want %0d", count, mdl_cnt); else pass_cnt++;
      write_move(3'd7, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      total_cnt++; if (count !== 6'(mdl_cnt)) $display("FAIL bad_count2: got %0d want %0d", count, mdl_cnt); else pass_cnt++;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      repeat (20) @(negedge clock);
      total_cnt++; if (starts.size() != 0) $display("FAIL bad_no_start: got %0d starts want 0", starts.size()); else pass_cnt++;
      total_cnt++; if (sdone.size() != 0) $display("FAIL bad_no_seq_done: got %0d want 0", sdone.size()); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL bad_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (error !== 1'b1) $display("FAIL bad_sticky: got %b want 1", error); else pass_cnt++;
      do_reset();
      #1;
      total_cnt++; if (error !== 1'b0) $display("FAIL bad_clear: got %b want 0", error); else pass_cnt++;
   endtask

   task automatic test_full();
      int gc; logic [5:0] es;
      do_reset();
      clear_logs();
      for (int i = 0; i < DEPTH; i++)
         write_move(3'($urandom_range(0, NM - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clock);
      total_cnt++; if (count !== 6'(DEPTH)) $display("FAIL full_count: got %0d want %0d", count, DEPTH); else pass_cnt++;
      total_cnt++; if (move_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", move_ready); else pass_cnt++;
      write_move(3'd4, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      total_cnt++; if (count !== 6'(mdl_cnt)) $display("FAIL full_drop: got %0d want %0d", count, mdl_cnt); else pass_cnt++;
      pulse_go(gc);
      es = 6'b1 << exp_q[0].face;
      total_cnt++; if (motor_start !== es) $display("FAIL full_head: got %b want %b", motor_start, es); else pass_cnt++;
      @(negedge clock);
      total_cnt++; if (move_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", move_ready); else pass_cnt++;
      total_cnt++; if (count !== 6'(DEPTH - 1)) $display("FAIL full_count_after_pop: got %0d want %0d", count, DEPTH - 1); else pass_cnt++;
      do_reset();
      repeat (200) @(negedge clock);
   endtask

   task automatic test_reset_mid();
      int gc;
      do_reset();
      clear_logs();
      write_move(3'd4, 1'b1, 1'b1, 1'b0);
      pulse_go(gc);
      #1 reset = 1'b1;
      #1;
      total_cnt++; if (motor_start !== '0) $display("FAIL rst_issue_start: got %b want 0", motor_start); else pass_cnt++;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete(); mdl_cnt = 0; mdl_dir = '0;
      repeat (200) @(negedge clock);
      clear_logs();
      for (int i = 0; i < 5; i++)
         write_move(3'($urandom_range(0, NM - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      pulse_go(gc);
      repeat (10) @(negedge clock);
      total_cnt++; if (count !== 6'(mdl_cnt)) $display("FAIL rst_pre_count: got %0d want %0d", count, mdl_cnt); else pass_cnt++;
      #1 reset = 1'b1;
      #1;
      total_cnt++; if (count !== '0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (motor_start !== '0) $display("FAIL rst_start: got %b want 0", motor_start); else pass_cnt++;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete(); mdl_cnt = 0; mdl_dir = '0;
      clear_logs();
      pulse_go(gc);
      repeat (20) @(negedge clock);
      total_cnt++; if (starts.size() != 0) $display("FAIL rst_no_issue: got %0d starts want 0", starts.size()); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy_after_go: got %b want 0", busy); else pass_cnt++;
   endtask

   initial begin : main
      test_reset();
      test_single();
      test_sequence(1'b0, 3);
      test_sequence(1'b1, 5);
      test_slow_ack();
      test_bad_face();
      test_full();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
